// File: rtl/nn_pkg.sv
// Shared types and sizing helpers for the sequential threshold-network evaluator.
package nn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_ACT,
    ST_DONE
  } state_e;

  // Every neuron stores its fan-in weights followed by one threshold word.
  function automatic int weight_words(int ni, int nh, int no);
    return nh * (ni + 1) + no * (nh + 1);
  endfunction

  function automatic int weights_width(int dw, int ni, int nh, int no);
    return dw * weight_words(ni, nh, no);
  endfunction

  function automatic int hidden_base();
    return 0;
  endfunction

  function automatic int output_base(int ni, int nh);
    return nh * (ni + 1);
  endfunction

  function automatic int fix_one(int dw);
    return 1 << (dw / 2);
  endfunction

endpackage

// File: rtl/nn_mac_unit.sv
// Fixed-point multiply (product >> DATA_WIDTH/2, truncated) feeding the accumulate adder.
module nn_mac_unit #(
  parameter int DATA_WIDTH = 16,
  parameter int SATURATE   = 0
) (
  input  logic [DATA_WIDTH-1:0] x_i,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] acc_i,
  output logic [DATA_WIDTH-1:0] acc_o
);

  logic [2*DATA_WIDTH-1:0] product;
  logic [DATA_WIDTH-1:0]   term;
  logic [DATA_WIDTH:0]     sum;

  assign product = {{DATA_WIDTH{1'b0}}, x_i} * {{DATA_WIDTH{1'b0}}, w_i};
  assign term    = DATA_WIDTH'(product >> (DATA_WIDTH / 2));
  assign sum     = {1'b0, acc_i} + {1'b0, term};

  // The carry out of the add is the overflow indicator used for clamping.
  assign acc_o = ((SATURATE != 0) && sum[DATA_WIDTH]) ? '1 : sum[DATA_WIDTH-1:0];

endmodule

// File: rtl/nn_seq_eval.sv
// Two-layer threshold network evaluated one weight per cycle through a shared MAC.
module nn_seq_eval
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int INPUT_SIZE  = 2,
  parameter int HIDDEN_SIZE = 3,
  parameter int OUTPUT_SIZE = 2,
  parameter int SATURATE    = 0,
  parameter int ACTIVATION  = 0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0]     input_data,
  input  logic [weights_width(DATA_WIDTH, INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE)-1:0] weights,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH*OUTPUT_SIZE-1:0]    output_data
);

  localparam int NWORDS = weight_words(INPUT_SIZE, HIDDEN_SIZE, OUTPUT_SIZE);
  localparam int HBASE  = hidden_base();
  localparam int OBASE  = output_base(INPUT_SIZE, HIDDEN_SIZE);
  localparam int MAXFAN = (INPUT_SIZE > HIDDEN_SIZE) ? INPUT_SIZE : HIDDEN_SIZE;
  localparam int MAXN   = (HIDDEN_SIZE > OUTPUT_SIZE) ? HIDDEN_SIZE : OUTPUT_SIZE;
  localparam int IW     = $clog2(MAXFAN + 1);
  localparam int NW     = $clog2(MAXN + 1);
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(fix_one(DATA_WIDTH));

  state_e                state_q, state_d;
  logic                  layer_q, layer_d;
  logic [NW-1:0]         neuron_q, neuron_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] in_q [INPUT_SIZE];
  logic [DATA_WIDTH-1:0] in_d [INPUT_SIZE];
  logic [DATA_WIDTH-1:0] hidden_q [HIDDEN_SIZE];
  logic [DATA_WIDTH-1:0] hidden_d [HIDDEN_SIZE];
  logic [DATA_WIDTH-1:0] out_q [OUTPUT_SIZE];
  logic [DATA_WIDTH-1:0] out_d [OUTPUT_SIZE];

  logic                  last_term, last_neuron;
  int                    w_idx;
  logic [DATA_WIDTH-1:0] x_sel, w_sel, mac_acc, act_res;

  assign last_term   = layer_q ? (idx_q == IW'(HIDDEN_SIZE - 1)) : (idx_q == IW'(INPUT_SIZE - 1));
  assign last_neuron = layer_q ? (neuron_q == NW'(OUTPUT_SIZE - 1)) : (neuron_q == NW'(HIDDEN_SIZE - 1));

  // In ACT the term index equals the fan-in, so the same mux lands on the threshold word.
  always_comb begin
    w_idx = layer_q ? OBASE + int'(neuron_q) * (HIDDEN_SIZE + 1) + int'(idx_q)
                    : HBASE + int'(neuron_q) * (INPUT_SIZE + 1) + int'(idx_q);
    w_sel = '0;
    for (int k = 0; k < NWORDS; k++) begin
      if (w_idx == k) w_sel = weights[k*DATA_WIDTH +: DATA_WIDTH];
    end
    x_sel = '0;
    if (layer_q) begin
      for (int h = 0; h < HIDDEN_SIZE; h++) begin
        if (idx_q == IW'(h)) x_sel = hidden_q[h];
      end
    end else begin
      for (int i = 0; i < INPUT_SIZE; i++) begin
        if (idx_q == IW'(i)) x_sel = in_q[i];
      end
    end
  end

  nn_mac_unit #(
    .DATA_WIDTH(DATA_WIDTH),
    .SATURATE  (SATURATE)
  ) u_mac (
    .x_i  (x_sel),
    .w_i  (w_sel),
    .acc_i(acc_q),
    .acc_o(mac_acc)
  );

  always_comb begin
    act_res = '0;
    if (acc_q >= w_sel) act_res = (ACTIVATION == 0) ? ONE : acc_q - w_sel;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      layer_q  <= 1'b0;
      neuron_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      for (int i = 0; i < INPUT_SIZE; i++) in_q[i] <= '0;
      for (int h = 0; h < HIDDEN_SIZE; h++) hidden_q[h] <= '0;
      for (int o = 0; o < OUTPUT_SIZE; o++) out_q[o] <= '0;
    end else begin
      state_q  <= state_d;
      layer_q  <= layer_d;
      neuron_q <= neuron_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      for (int i = 0; i < INPUT_SIZE; i++) in_q[i] <= in_d[i];
      for (int h = 0; h < HIDDEN_SIZE; h++) hidden_q[h] <= hidden_d[h];
      for (int o = 0; o < OUTPUT_SIZE; o++) out_q[o] <= out_d[o];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (in_valid) state_d = ST_MAC;
      ST_MAC:  if (last_term) state_d = ST_ACT;
      ST_ACT:  state_d = (last_neuron && layer_q) ? ST_DONE : ST_MAC;
      ST_DONE: if (out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    layer_d  = layer_q;
    neuron_d = neuron_q;
    idx_d    = idx_q;
    acc_d    = acc_q;
    in_d     = in_q;
    hidden_d = hidden_q;
    out_d    = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          for (int i = 0; i < INPUT_SIZE; i++) in_d[i] = input_data[i*DATA_WIDTH +: DATA_WIDTH];
          layer_d  = 1'b0;
          neuron_d = '0;
          idx_d    = '0;
          acc_d    = '0;
        end
      end
      ST_MAC: begin
        acc_d = mac_acc;
        idx_d = idx_q + IW'(1);
      end
      ST_ACT: begin
        if (layer_q) begin
          for (int o = 0; o < OUTPUT_SIZE; o++) begin
            if (neuron_q == NW'(o)) out_d[o] = act_res;
          end
        end else begin
          for (int h = 0; h < HIDDEN_SIZE; h++) begin
            if (neuron_q == NW'(h)) hidden_d[h] = act_res;
          end
        end
        acc_d = '0;
        idx_d = '0;
        if (last_neuron) begin
          layer_d  = 1'b1;
          neuron_d = '0;
        end else begin
          neuron_d = neuron_q + NW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == ST_IDLE);
    out_valid   = (state_q == ST_DONE);
    output_data = '0;
    for (int o = 0; o < OUTPUT_SIZE; o++) output_data[o*DATA_WIDTH +: DATA_WIDTH] = out_q[o];
  end

endmodule

// File: tb/tb_nn_seq_eval.sv
// Bench for nn_seq_eval: three builds (wrap/step, saturate/step, wrap/ramp) share one stimulus.
module tb_nn_seq_eval;

  localparam int DW = 16;
  localparam int NI = 2;
  localparam int NH = 3;
  localparam int NO = 2;
  localparam int NWORDS = NH * (NI + 1) + NO * (NH + 1);
  localparam int LAT = 17;
  localparam int ND = 3;
  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic                   clk = 1'b0;
  logic                   reset = 1'b1;
  logic                   in_valid = 1'b0;
  logic                   out_ready = 1'b0;
  logic [DW*NI-1:0]       input_data = '0;
  logic [DW*NWORDS-1:0]   weights = '0;
  logic                   inReady [ND];
  logic                   outValid [ND];
  logic [DW*NO-1:0]       outData [ND];

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  logic [15:0] xArr [NI];
  logic [15:0] wArr [NWORDS];

  int          mState = M_IDLE;
  int          mCnt = 0;
  logic [31:0] expOut [ND] = '{default: '0};
  logic [31:0] pend [ND] = '{default: '0};

  always #5 clk = ~clk;

  nn_seq_eval #(.SATURATE(0), .ACTIVATION(0)) dutWrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady[0]),
    .input_data(input_data), .weights(weights), .out_valid(outValid[0]),
    .out_ready(out_ready), .output_data(outData[0]));

  nn_seq_eval #(.SATURATE(1), .ACTIVATION(0)) dutSat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady[1]),
    .input_data(input_data), .weights(weights), .out_valid(outValid[1]),
    .out_ready(out_ready), .output_data(outData[1]));

  nn_seq_eval #(.SATURATE(0), .ACTIVATION(1)) dutRamp (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(inReady[2]),
    .input_data(input_data), .weights(weights), .out_valid(outValid[2]),
    .out_ready(out_ready), .output_data(outData[2]));

  function automatic longint addTerm(longint acc, longint x, longint w, int sat);
    longint p;
    p = ((x * w) >> 8) % 65536;
    acc = acc + p;
    if (acc > 65535) acc = (sat != 0) ? 65535 : acc - 65536;
    return acc;
  endfunction

  function automatic longint activate(longint acc, longint thr, int ramp);
    if (acc < thr) return 0;
    return (ramp != 0) ? acc - thr : 256;
  endfunction

  function automatic logic [31:0] modelEval(int sat, int ramp);
    longint hid [NH];
    longint acc;
    longint r;
    int base;
    logic [31:0] res;
    res = '0;
    for (int h = 0; h < NH; h++) begin
      base = h * (NI + 1);
      acc = 0;
      for (int i = 0; i < NI; i++) acc = addTerm(acc, xArr[i], wArr[base + i], sat);
      hid[h] = activate(acc, wArr[base + NI], ramp);
    end
    for (int o = 0; o < NO; o++) begin
      base = NH * (NI + 1) + o * (NH + 1);
      acc = 0;
      for (int h = 0; h < NH; h++) acc = addTerm(acc, hid[h], wArr[base + h], sat);
      r = activate(acc, wArr[base + NH], ramp);
      res[o*16 +: 16] = r[15:0];
    end
    return res;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mState = M_IDLE;
      mCnt = 0;
      for (int d = 0; d < ND; d++) expOut[d] = '0;
    end else if (mState == M_IDLE) begin
      if (in_valid) begin
        pend[0] = modelEval(0, 0);
        pend[1] = modelEval(1, 0);
        pend[2] = modelEval(0, 1);
        mState = M_BUSY;
        mCnt = LAT;
      end
    end else if (mState == M_BUSY) begin
      mCnt = mCnt - 1;
      if (mCnt == 0) begin
        mState = M_DONE;
        for (int d = 0; d < ND; d++) expOut[d] = pend[d];
      end
    end else if (out_ready) begin
      mState = M_IDLE;
    end
  end

  task automatic checkOutput(string name, int d, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d: got %h, expected %h", name, d, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (checkEn) begin
      for (int d = 0; d < ND; d++) begin
        checkOutput("model_in_ready", d, 32'(inReady[d]), 32'(mState == M_IDLE));
        checkOutput("model_out_valid", d, 32'(outValid[d]), 32'(mState == M_DONE));
        if (mState != M_BUSY) checkOutput("model_output_data", d, outData[d], expOut[d]);
      end
    end
  end

  task automatic loadVector(logic [15:0] x0, logic [15:0] x1, logic [15:0] wv,
                            logic [15:0] hthr, logic [15:0] othr);
    xArr[0] = x0;
    xArr[1] = x1;
    for (int k = 0; k < NWORDS; k++) wArr[k] = wv;
    for (int h = 0; h < NH; h++) wArr[h*(NI+1) + NI] = hthr;
    for (int o = 0; o < NO; o++) wArr[NH*(NI+1) + o*(NH+1) + NH] = othr;
    input_data = {xArr[1], xArr[0]};
    for (int k = 0; k < NWORDS; k++) weights[k*DW +: DW] = wArr[k];
  endtask

  task automatic applyStimulus(logic [15:0] x0, logic [15:0] x1, logic [15:0] wv,
                               logic [15:0] hthr, logic [15:0] othr);
    loadVector(x0, x1, wv, hthr, othr);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic waitDone(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!outValid[0] && lat < 100);
    if (!outValid[0]) checkOutput("wait_out_valid_timeout", 0, 32'(outValid[0]), 32'd1);
  endtask

  task automatic releaseResult();
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    checkOutput("idle_after_handshake", 0, 32'(inReady[0]), 32'd1);
  endtask

  task automatic checkAll(string name, logic [31:0] e0, logic [31:0] e1, logic [31:0] e2);
    checkOutput(name, 0, outData[0], e0);
    checkOutput(name, 1, outData[1], e1);
    checkOutput(name, 2, outData[2], e2);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int lat;
    int got;
    int guard;
    loadVector(16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1 checkEn = 1'b1;
    reset = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checkOutput("reset_in_ready", d, 32'(inReady[d]), 32'd1);
      checkOutput("reset_out_valid", d, 32'(outValid[d]), 32'd0);
      checkOutput("reset_output_data", d, outData[d], 32'h0);
    end

    $display("[TB] basic step vector, latency and held output");
    applyStimulus(16'h0100, 16'h0080, 16'h0100, 16'h0180, 16'h0300);
    waitDone(lat);
    checkOutput("latency", 0, 32'(lat), 32'(LAT));
    checkAll("basic_result", 32'h01000100, 32'h01000100, 32'h00000000);
    repeat (10) @(posedge clk);
    #1 checkAll("held_result", 32'h01000100, 32'h01000100, 32'h00000000);
    checkOutput("held_in_ready", 0, 32'(inReady[0]), 32'd0);
    checkOutput("held_out_valid", 0, 32'(outValid[0]), 32'd1);
    releaseResult();

    $display("[TB] output threshold one above accumulator");
    applyStimulus(16'h0100, 16'h0080, 16'h0100, 16'h0180, 16'h0301);
    waitDone(lat);
    checkAll("thr_plus_one", 32'h0, 32'h0, 32'h0);
    releaseResult();

    $display("[TB] overflow: wrap versus saturate");
    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFD00, 16'hFFFF);
    waitDone(lat);
    checkAll("overflow", 32'h0, 32'h01000100, 32'h0);
    releaseResult();

    $display("[TB] ramp activation");
    applyStimulus(16'h0100, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
    waitDone(lat);
    checkAll("ramp", 32'h01000100, 32'h01000100, 32'h00800080);
    releaseResult();

    $display("[TB] reset during MAC, together with in_valid");
    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFD00, 16'hFFFF);
    repeat (5) @(posedge clk);
    #1 reset = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    in_valid = 1'b0;
    for (int d = 0; d < ND; d++) begin
      checkOutput("abort_in_ready", d, 32'(inReady[d]), 32'd1);
      checkOutput("abort_out_valid", d, 32'(outValid[d]), 32'd0);
    end
    checkAll("abort_output_data", 32'h0, 32'h0, 32'h0);
    applyStimulus(16'h0100, 16'h0080, 16'h0100, 16'h0100, 16'h0100);
    waitDone(lat);
    checkOutput("post_abort_latency", 0, 32'(lat), 32'(LAT));
    checkAll("post_abort", 32'h01000100, 32'h01000100, 32'h00800080);
    releaseResult();

    $display("[TB] back-to-back with out_ready held high");
    loadVector(16'h0100, 16'h0080, 16'h0100, 16'h0180, 16'h0300);
    in_valid = 1'b1;
    out_ready = 1'b1;
    got = 0;
    guard = 0;
    while (got < 2 && guard < 100) begin
      @(posedge clk);
      #1 guard++;
      if (outValid[0]) begin
        got++;
        checkAll("b2b_result", 32'h01000100, 32'h01000100, 32'h00000000);
      end
    end
    checkOutput("b2b_results", 0, 32'(got), 32'd2);
    in_valid = 1'b0;
    repeat (25) @(posedge clk);
    #1 out_ready = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
